data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, meaning word-addressed storage depth; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, meaning wait states between accept and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU-side load/store request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 addr  input  32  byte address; bits [1:0] select byte lane.
REQ-008 wr_en  input  1  1 = store, 0 = load (CPU DmWr).
REQ-009 dm_ctrl  input  3  access size/sign (CPU DMCtrl): 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-010 wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle pulse: access complete, rdata/err valid.
REQ-012 rdata  output  32  load result, sign- or zero-extended per dm_ctrl; 0 for stores.
REQ-013 err  output  1  access faulted; qualified by rsp_valid.

Function
REQ-014 States: IDLE, WAIT, RESP; handshake completes when req_valid && req_ready in the same cycle.
REQ-015 req_ready is 1 only in IDLE; addr, wr_en, dm_ctrl and wdata are captured on accept.
REQ-016 IDLE->WAIT on accept if WAIT_CYCLES>0, else IDLE->RESP; WAIT counts down from WAIT_CYCLES-1 and moves to RESP when the count reaches 0.
REQ-017 RESP lasts exactly one cycle with rsp_valid=1, then returns to IDLE; total latency from accept to rsp_valid = WAIT_CYCLES+1 cycles.
REQ-018 No back-to-back accept: the earliest next accept is the cycle after RESP.
REQ-019 Store commits to storage on the clock edge that enters RESP; sb/sh modify only the addressed byte lanes, other lanes preserved.
REQ-020 Load reads the word at addr[log2(DEPTH_WORDS)+1:2] and extracts the lane selected by addr[1:0]; signed forms sign-extend bit 7/15, unsigned forms zero-extend.
REQ-021 Address wrap: word index is taken modulo DEPTH_WORDS, with upper address bits ignored.
REQ-022 Illegal dm_ctrl (011, 110, 111) sets err=1 and rdata=0, and a store with an illegal dm_ctrl performs no write.
REQ-023 Outputs rdata and err are held at 0 whenever rsp_valid=0.

Reset
REQ-024 On rst_n low: state=IDLE, wait counter=0, req_ready=0 while asserted, rsp_valid=0, rdata=0, err=0.
REQ-025 Reset asserted in WAIT abandons the access, so a pending store is never committed.
REQ-026 Storage contents are not reset and hold their values across reset.
REQ-027 req_ready rises in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN: when defined, half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 return err=1, rdata=0, and no write.
REQ-029 Without DMEM_MISALIGN_TRAP_EN, misaligned accesses are force-aligned (addr low bits cleared to the access size) and complete with err=0.

Structure
REQ-030 Shared package dmem_pkg holds the dm_ctrl encoding enum, the state enum (IDLE, WAIT, RESP), and the lane-mask width constants.
REQ-031 One combinational sub-module, dmem_lane_align, performs the byte-enable/write-merge and load extract/extend functions; the FSM, counter and storage stay in data_mem_responder.

Verification
REQ-032 Store word 0xDEADBEEF at 0x10, then load word from 0x10 -> rsp_valid 2 cycles after each accept (WAIT_CYCLES=1), rdata=0xDEADBEEF, err=0.
REQ-033 After REQ-032, sb 0x7F at 0x12, then lb 0x12 and lw 0x10 -> rdata=0x0000007F, then 0xDE7FBEEF.
REQ-034 lb at 0x13 returns 0xFFFFFFDE and lbu at 0x13 returns 0x000000DE; lh at 0x12 returns 0xFFFFDE7F.
REQ-035 Store at 0x10 with rst_n pulsed low during WAIT (WAIT_CYCLES=3), then lw 0x10 -> old value unchanged, no rsp_valid for the aborted access.
REQ-036 lw at 0x11: with DMEM_MISALIGN_TRAP_EN -> err=1, rdata=0; without it -> data of 0x10, err=0; dm_ctrl=111 -> err=1 in both builds.
REQ-037 req_valid held high continuously with WAIT_CYCLES=0 -> accepts every 2 cycles, req_ready=0 in RESP, one rsp_valid per accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro used by this slice: DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = DATA_W / LANE_W;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [2:0] {
        DM_BYTE  = 3'b000,
        DM_HALF  = 3'b001,
        DM_WORD  = 3'b010,
        DM_BYTEU = 3'b100,
        DM_HALFU = 3'b101
    } dm_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane write merge and load extract/extend for one 32-bit word.
// With DMEM_MISALIGN_TRAP_EN defined, misaligned half/word accesses fault.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]        dm_ctrl,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [DATA_W-1:0] wword,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic [1:0]           lane;
    logic [NUM_LANES-1:0] be_base;
    logic [NUM_LANES-1:0] be;
    logic [DATA_W-1:0]    wrep;
    logic [DATA_W-1:0]    shifted;

    always_comb begin
        lane    = byte_off;
        be_base = '0;
        wrep    = wdata;
        err     = 1'b0;
        rdata   = '0;
        wword   = rword;

        // Without the trap, half/word offsets are force-aligned by clearing low bits.
        case (dm_ctrl)
            DM_BYTE, DM_BYTEU: begin
                lane    = byte_off;
                be_base = 4'b0001;
                wrep    = {4{wdata[7:0]}};
            end
            DM_HALF, DM_HALFU: begin
                lane    = {byte_off[1], 1'b0};
                be_base = 4'b0011;
                wrep    = {2{wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
                err     = byte_off[0];
`endif
            end
            DM_WORD: begin
                lane    = 2'b00;
                be_base = 4'b1111;
                wrep    = wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                err     = |byte_off;
`endif
            end
            default: err = 1'b1;
        endcase

        shifted = rword >> {lane, 3'b000};

        case (dm_ctrl)
            DM_BYTE:  rdata = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTEU: rdata = {24'h0, shifted[7:0]};
            DM_HALF:  rdata = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALFU: rdata = {16'h0, shifted[15:0]};
            DM_WORD:  rdata = shifted;
            default:  rdata = '0;
        endcase

        be = err ? '0 : (be_base << lane);
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            wword[i*LANE_W +: LANE_W] = be[i] ? wrep[i*LANE_W +: LANE_W]
                                              : rword[i*LANE_W +: LANE_W];
        end

        if (err) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a valid/ready request side and a wait-stated response.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [2:0]  dm_ctrl,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned WAIT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_INIT_I);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic               wr_q, wr_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic [DATA_W-1:0]  mem [DEPTH_WORDS];

    logic               accept;
    logic               commit;
    logic [IDX_W+1:0]   op_addr;
    logic               op_wr;
    logic [2:0]         op_ctrl;
    logic [DATA_W-1:0]  op_wdata;
    logic [IDX_W-1:0]   op_idx;
    logic [DATA_W-1:0]  rword;
    logic [DATA_W-1:0]  merged_word;
    logic [DATA_W-1:0]  load_data;
    logic               access_err;
    logic               addr_unused;

    assign addr_unused = ^addr[31:IDX_W+2];

    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);

    // With no wait states the commit edge is the accept edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            op_addr  = addr[IDX_W+1:0];
            op_wr    = wr_en;
            op_ctrl  = dm_ctrl;
            op_wdata = wdata;
        end else begin
            op_addr  = addr_q;
            op_wr    = wr_q;
            op_ctrl  = ctrl_q;
            op_wdata = wdata_q;
        end
    end

    assign op_idx = op_addr[IDX_W+1:2];
    assign rword  = mem[op_idx];

    dmem_lane_align u_lane_align (
        .dm_ctrl  (op_ctrl),
        .byte_off (op_addr[1:0]),
        .wdata    (op_wdata),
        .rword    (rword),
        .wword    (merged_word),
        .rdata    (load_data),
        .err      (access_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        ctrl_d  = ctrl_q;
        wdata_d = wdata_q;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = addr[IDX_W+1:0];
                    wr_d    = wr_en;
                    ctrl_d  = dm_ctrl;
                    wdata_d = wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            ctrl_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            ctrl_q  <= ctrl_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && op_wr && !access_err) begin
            mem[op_idx] <= merged_word;
        end
    end

    assign rdata = (rsp_valid && !wr_q) ? load_data : '0;
    assign err   = rsp_valid && access_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at WAIT_CYCLES of 1, 3 and 0.
// Expectations for misaligned accesses follow DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rv;
    logic [31:0] addr;
    logic        wr_en;
    logic [2:0]  dm_ctrl;
    logic [31:0] wdata;

    logic        rdy_w1, rdy_w3, rdy_w0;
    logic        rsp_w1, rsp_w3, rsp_w0;
    logic        err_w1, err_w3, err_w0;
    logic [31:0] rd_w1, rd_w3, rd_w0;

    int total = 0;
    int bad = 0;
    int idle_nonzero = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy_w1),
        .addr(addr), .wr_en(wr_en), .dm_ctrl(dm_ctrl), .wdata(wdata),
        .rsp_valid(rsp_w1), .rdata(rd_w1), .err(err_w1)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy_w3),
        .addr(addr), .wr_en(wr_en), .dm_ctrl(dm_ctrl), .wdata(wdata),
        .rsp_valid(rsp_w3), .rdata(rd_w3), .err(err_w3)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rdy_w0),
        .addr(addr), .wr_en(wr_en), .dm_ctrl(dm_ctrl), .wdata(wdata),
        .rsp_valid(rsp_w0), .rdata(rd_w0), .err(err_w0)
    );

    always @(negedge clk) begin
        if (!rsp_w1 && (rd_w1 != 32'h0 || err_w1)) idle_nonzero++;
        if (!rsp_w3 && (rd_w3 != 32'h0 || err_w3)) idle_nonzero++;
        if (!rsp_w0 && (rd_w0 != 32'h0 || err_w0)) idle_nonzero++;
    end

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 3 : 0;
    endfunction

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? rdy_w1 : (sel == 1) ? rdy_w3 : rdy_w0;
    endfunction

    function automatic logic rsp_of(input int sel);
        return (sel == 0) ? rsp_w1 : (sel == 1) ? rsp_w3 : rsp_w0;
    endfunction

    function automatic logic err_of(input int sel);
        return (sel == 0) ? err_w1 : (sel == 1) ? err_w3 : err_w0;
    endfunction

    function automatic logic [31:0] rd_of(input int sel);
        return (sel == 0) ? rd_w1 : (sel == 1) ? rd_w3 : rd_w0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input int sel, input logic wr, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int  lat;
        bit  got;
        @(negedge clk);
        addr    = a;
        wr_en   = wr;
        dm_ctrl = ctrl;
        wdata   = wd;
        rv[sel] = 1'b1;
        check_eq({tag, ".rdy"}, 32'(rdy_of(sel)), 32'd1);
        @(posedge clk);
        #1 rv[sel] = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_of(sel)) got = 1'b1;
        end
        check_eq({tag, ".lat"}, 32'(lat), 32'(wait_of(sel) + 1));
        check_eq({tag, ".rdata"}, rd_of(sel), exp_rd);
        check_eq({tag, ".err"}, 32'(err_of(sel)), 32'(exp_err));
    endtask

    initial begin
        int n;
        int rdy_cnt;
        int rsp_cnt;
        rst_n   = 1'b0;
        rv      = '0;
        addr    = '0;
        wr_en   = 1'b0;
        dm_ctrl = 3'b010;
        wdata   = '0;

        repeat (3) @(negedge clk);
        check_eq("rst.rdy", {29'h0, rdy_w1, rdy_w3, rdy_w0}, 32'h0);
        check_eq("rst.rsp", {29'h0, rsp_w1, rsp_w3, rsp_w0}, 32'h0);
        check_eq("rst.rdata", rd_w1, 32'h0);
        check_eq("rst.err", 32'(err_w1), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst.rdy_after", {29'h0, rdy_w1, rdy_w3, rdy_w0}, 32'h7);

        access(0, 1'b1, DM_WORD,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
        access(0, 1'b0, DM_WORD,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
        access(0, 1'b1, DM_BYTE,  32'h12, 32'h0000007F, 32'h0, 1'b0, "sb12");
        access(0, 1'b0, DM_BYTE,  32'h12, 32'h0, 32'h0000007F, 1'b0, "lb12");
        access(0, 1'b0, DM_WORD,  32'h10, 32'h0, 32'hDE7FBEEF, 1'b0, "lw10b");
        access(0, 1'b0, DM_BYTE,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");
        access(0, 1'b0, DM_BYTEU, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu13");
        access(0, 1'b0, DM_HALF,  32'h12, 32'h0, 32'hFFFFDE7F, 1'b0, "lh12");
        access(0, 1'b0, DM_HALFU, 32'h12, 32'h0, 32'h0000DE7F, 1'b0, "lhu12");
        access(0, 1'b0, DM_WORD,  32'h410, 32'h0, 32'hDE7FBEEF, 1'b0, "wrap410");
        access(0, 1'b0, DM_WORD,  32'h80000010, 32'h0, 32'hDE7FBEEF, 1'b0, "wraphi");

        access(0, 1'b1, DM_WORD,  32'h20, 32'h11223344, 32'h0, 1'b0, "sw20");
        access(0, 1'b1, DM_HALF,  32'h22, 32'h0000BEEF, 32'h0, 1'b0, "sh22");
        access(0, 1'b0, DM_WORD,  32'h20, 32'h0, 32'hBEEF3344, 1'b0, "lw20");

        access(0, 1'b0, 3'b111,   32'h10, 32'h0, 32'h0, 1'b1, "ill111");
        access(0, 1'b1, 3'b011,   32'h10, 32'h0, 32'h0, 1'b1, "ill_st");
        access(0, 1'b0, DM_WORD,  32'h10, 32'h0, 32'hDE7FBEEF, 1'b0, "ill_nowr");

`ifdef DMEM_MISALIGN_TRAP_EN
        access(0, 1'b0, DM_WORD,  32'h11, 32'h0, 32'h0, 1'b1, "mis_lw11");
        access(0, 1'b1, DM_HALF,  32'h21, 32'h00005555, 32'h0, 1'b1, "mis_sh21");
        access(0, 1'b0, DM_WORD,  32'h20, 32'h0, 32'hBEEF3344, 1'b0, "mis_lw20");
`else
        access(0, 1'b0, DM_WORD,  32'h11, 32'h0, 32'hDE7FBEEF, 1'b0, "mis_lw11");
        access(0, 1'b1, DM_HALF,  32'h21, 32'h00005555, 32'h0, 1'b0, "mis_sh21");
        access(0, 1'b0, DM_WORD,  32'h20, 32'h0, 32'hBEEF5555, 1'b0, "mis_lw20");
`endif

        // Abort a store mid-WAIT on the three-wait-state instance.
        access(1, 1'b1, DM_WORD,  32'h10, 32'hCAFEF00D, 32'h0, 1'b0, "w3.sw");
        @(negedge clk);
        addr    = 32'h10;
        wr_en   = 1'b1;
        dm_ctrl = DM_WORD;
        wdata   = 32'h0BADBEEF;
        rv[1]   = 1'b1;
        @(posedge clk);
        #1 rv[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        n = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_w3) n++;
        end
        check_eq("abort.rdy_in_rst", 32'(rdy_w3), 32'h0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_w3) n++;
        end
        check_eq("abort.no_rsp", 32'(n), 32'h0);
        access(1, 1'b0, DM_WORD,  32'h10, 32'h0, 32'hCAFEF00D, 1'b0, "abort.lw");

        // Zero wait states with req_valid held high.
        access(2, 1'b1, DM_WORD,  32'h30, 32'h13579BDF, 32'h0, 1'b0, "w0.sw");
        @(negedge clk);
        addr    = 32'h30;
        wr_en   = 1'b0;
        dm_ctrl = DM_WORD;
        rv[2]   = 1'b1;
        rdy_cnt = 0;
        rsp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (rdy_w0) rdy_cnt++;
            if (rsp_w0) begin
                rsp_cnt++;
                check_eq("w0.rsp_rdy", 32'(rdy_w0), 32'h0);
                check_eq("w0.rsp_data", rd_w0, 32'h13579BDF);
            end
            check_eq("w0.rsp_phase", 32'(rsp_w0), 32'(i % 2));
            @(negedge clk);
        end
        rv[2] = 1'b0;
        check_eq("w0.accepts", 32'(rdy_cnt), 32'd4);
        check_eq("w0.rsps", 32'(rsp_cnt), 32'd4);

        repeat (2) @(negedge clk);
        check_eq("idle_outputs_zero", 32'(idle_nonzero), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
